i2c_target: RTL and testbench

- I2C responder (target) paired with the core-side I2C controller; gives an external I2C master byte access to an 8-bit-addressed register space owned by the RISC-V core.
- Oversamples SCL/SDA on the system clock, decodes START/STOP/address/data, and drives SDA open-drain.
- Register accesses are presented to the core as single-cycle write pulses and read requests.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_target_if.sv | 25 ++
 rtl/i2c_sync_edge.sv | 32 +++
 rtl/i2c_target.sv | 173 +++++++++++++++++
 tb/tb_i2c_target.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus-level constants for the I2C target
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WPTR,
        WPTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } i2c_state_t;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - pin and register-access signals between the I2C target and its core
interface i2c_target_if;

    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       wr_valid;
    logic [7:0] wr_ptr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_ptr;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, rd_data,
        output sda_oe, wr_valid, wr_ptr, wr_data, rd_req, rd_ptr, busy
    );

    modport master (
        output scl_i, sda_i, rd_data,
        input  sda_oe, wr_valid, wr_ptr, wr_data, rd_req, rd_ptr, busy
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - two-flop synchroniser with one history flop for edge detection
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic hist;

    // Preset high so an idle (pulled-up) bus produces no spurious edges out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            hist <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            hist <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~hist;
    assign fall  = ~sync & hist;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target giving an external master byte access to an 8-bit register space
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         PTR_INC  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    i2c_target_if.slave  bus
);

    localparam logic [7:0] INC = (PTR_INC != 0) ? 8'd1 : 8'd0;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl (.clk(clk), .rst_n(rst_n), .din(bus.scl_i),
                         .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_sync_edge u_sda (.clk(clk), .rst_n(rst_n), .din(bus.sda_i),
                         .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    wire start_det = sda_fall & scl_lvl;
    wire stop_det  = sda_rise & scl_lvl;

    i2c_state_t state, state_d;
    logic [3:0] bitcnt, bitcnt_d;
    logic [7:0] shreg, shreg_d, ptr, ptr_d;
    logic       rw, rw_d;
    logic       oe, oe_d, wr_valid, wr_valid_d, rd_req, rd_req_d, busy, busy_d;
    logic [7:0] wr_ptr, wr_ptr_d, wr_data, wr_data_d, rd_ptr, rd_ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bitcnt   <= 4'd0;
            shreg    <= 8'h00;
            ptr      <= 8'h00;
            rw       <= 1'b0;
            oe       <= 1'b0;
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
            wr_ptr   <= 8'h00;
            wr_data  <= 8'h00;
            rd_ptr   <= 8'h00;
        end else begin
            state    <= state_d;
            bitcnt   <= bitcnt_d;
            shreg    <= shreg_d;
            ptr      <= ptr_d;
            rw       <= rw_d;
            oe       <= oe_d;
            wr_valid <= wr_valid_d;
            rd_req   <= rd_req_d;
            busy     <= busy_d;
            wr_ptr   <= wr_ptr_d;
            wr_data  <= wr_data_d;
            rd_ptr   <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d    = state;
        bitcnt_d   = bitcnt;
        shreg_d    = shreg;
        ptr_d      = ptr;
        rw_d       = rw;
        oe_d       = oe;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        busy_d     = busy;
        wr_ptr_d   = wr_ptr;
        wr_data_d  = wr_data;
        rd_ptr_d   = rd_ptr;

        if (start_det) begin
            state_d  = ADDR;
            bitcnt_d = 4'd0;
            oe_d     = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            // rd_data is combinational from rd_ptr, so it is valid in the rd_req cycle.
            if (rd_req) begin
                shreg_d = bus.rd_data;
                oe_d    = ~bus.rd_data[7];
            end
            if (scl_rise && bitcnt != 4'd8 &&
                (state == ADDR || state == WPTR || state == WDATA)) begin
                shreg_d  = {shreg[6:0], sda_lvl};
                bitcnt_d = bitcnt + 4'd1;
            end
            unique case (state)
                IDLE: ;
                ADDR: if (scl_fall && bitcnt == 4'd8) begin
                    if (shreg[7:1] == DEV_ADDR) begin
                        oe_d    = 1'b1;
                        rw_d    = shreg[0];
                        busy_d  = 1'b1;
                        state_d = ADDR_ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    oe_d     = 1'b0;
                    bitcnt_d = 4'd0;
                    if (rw == I2C_RW_READ) begin
                        rd_req_d = 1'b1;
                        rd_ptr_d = ptr;
                        bitcnt_d = 4'd1;
                        state_d  = RDATA;
                    end else begin
                        state_d = WPTR;
                    end
                end
                WPTR: if (scl_fall && bitcnt == 4'd8) begin
                    ptr_d   = shreg;
                    oe_d    = 1'b1;
                    state_d = WPTR_ACK;
                end
                WPTR_ACK, WDATA_ACK: if (scl_fall) begin
                    oe_d     = 1'b0;
                    bitcnt_d = 4'd0;
                    state_d  = WDATA;
                end
                WDATA: if (scl_fall && bitcnt == 4'd8) begin
                    oe_d       = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_ptr_d   = ptr;
                    wr_data_d  = shreg;
                    ptr_d      = ptr + INC;
                    state_d    = WDATA_ACK;
                end
                RDATA: if (scl_fall) begin
                    if (bitcnt == 4'd8) begin
                        oe_d    = 1'b0;
                        state_d = RDATA_ACK;
                    end else begin
                        shreg_d  = {shreg[6:0], 1'b0};
                        oe_d     = ~shreg[6];
                        bitcnt_d = bitcnt + 4'd1;
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr + INC;
                        if (sda_lvl == I2C_NACK) state_d = IDLE;
                    end else if (scl_fall) begin
                        rd_req_d = 1'b1;
                        rd_ptr_d = ptr;
                        bitcnt_d = 4'd1;
                        state_d  = RDATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d == IDLE) busy_d = 1'b0;
    end

    assign bus.sda_oe   = oe;
    assign bus.wr_valid = wr_valid;
    assign bus.wr_ptr   = wr_ptr;
    assign bus.wr_data  = wr_data;
    assign bus.rd_req   = rd_req;
    assign bus.rd_ptr   = rd_ptr;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed, table-driven bench for the I2C target
module tb_i2c_target;

    localparam int Q = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    i2c_target_if bus();

    i2c_target #(.DEV_ADDR(7'h42), .PTR_INC(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    assign bus.scl_i   = scl;
    assign bus.sda_i   = sda_m & ~bus.sda_oe;
    assign bus.rd_data = ~bus.rd_ptr;

    logic [15:0] wr_log [0:63];
    logic [7:0]  rd_log [0:63];
    int wr_n = 0, rd_n = 0, both_n = 0, oe_n = 0;

    always @(negedge clk) begin
        if (bus.wr_valid) begin
            wr_log[wr_n[5:0]] <= {bus.wr_ptr, bus.wr_data};
            wr_n <= wr_n + 1;
        end
        if (bus.rd_req) begin
            rd_log[rd_n[5:0]] <= bus.rd_ptr;
            rd_n <= rd_n + 1;
        end
        if (bus.wr_valid && bus.rd_req) both_n <= both_n + 1;
        if (bus.sda_oe) oe_n <= oe_n + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        clks(Q); sda_m = 1'b1; clks(Q); scl = 1'b1; clks(Q);
        sda_m = 1'b0; clks(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        clks(Q); sda_m = 1'b0; clks(Q); scl = 1'b1; clks(Q); sda_m = 1'b1; clks(Q);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        clks(Q); sda_m = b; clks(Q); scl = 1'b1; clks(Q); s = bus.sda_i; clks(Q); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(~mack, s);
    endtask

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] ep0;
        logic [7:0] ep1;
    } wvec_t;

    wvec_t wv [3];

    initial begin
        logic ack, s;
        logic [7:0] d;
        int base, rbase, obase;

        wv[0] = '{ptr: 8'h10, d0: 8'hA5, d1: 8'h5A, ep0: 8'h10, ep1: 8'h11};
        wv[1] = '{ptr: 8'hFF, d0: 8'h11, d1: 8'h22, ep0: 8'hFF, ep1: 8'h00};
        wv[2] = '{ptr: 8'h7F, d0: 8'h00, d1: 8'hFF, ep0: 8'h7F, ep1: 8'h80};

        clks(3);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_wr_valid", bus.wr_valid, 0);
        chk("rst_rd_req", bus.rd_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wr_ptr", bus.wr_ptr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_rd_ptr", bus.rd_ptr, 0);
        rst_n = 1'b1;
        clks(5);

        for (int i = 0; i < 3; i++) begin
            base = wr_n;
            i2c_start();
            write_byte(8'h84, ack); chk("w_addr_ack", ack, 1);
            chk("w_busy", bus.busy, 1);
            write_byte(wv[i].ptr, ack); chk("w_ptr_ack", ack, 1);
            write_byte(wv[i].d0, ack);  chk("w_d0_ack", ack, 1);
            write_byte(wv[i].d1, ack);  chk("w_d1_ack", ack, 1);
            i2c_stop();
            clks(4);
            chk("w_busy_after_stop", bus.busy, 0);
            chk("w_count", wr_n - base, 2);
            chk("w_first", wr_log[base[5:0]], {wv[i].ep0, wv[i].d0});
            chk("w_second", wr_log[base[5:0] + 6'd1], {wv[i].ep1, wv[i].d1});
        end

        base = wr_n;
        i2c_start();
        write_byte(8'h84, ack); chk("r_waddr_ack", ack, 1);
        write_byte(8'h20, ack); chk("r_ptr_ack", ack, 1);
        i2c_start();
        write_byte(8'h85, ack); chk("r_raddr_ack", ack, 1);
        rbase = rd_n;
        read_byte(1'b1, d); chk("r_byte0", d, 8'hDF);
        read_byte(1'b1, d); chk("r_byte1", d, 8'hDE);
        read_byte(1'b0, d); chk("r_byte2", d, 8'hDD);
        clks(4);
        chk("r_released_after_nack", bus.sda_oe, 0);
        chk("r_busy_after_nack", bus.busy, 0);
        chk("r_count", rd_n - rbase, 3);
        chk("r_ptr0", rd_log[rbase[5:0]], 8'h20);
        chk("r_ptr1", rd_log[rbase[5:0] + 6'd1], 8'h21);
        chk("r_ptr2", rd_log[rbase[5:0] + 6'd2], 8'h22);
        chk("r_no_write", wr_n - base, 0);
        i2c_stop();

        base = wr_n; rbase = rd_n; obase = oe_n;
        i2c_start();
        write_byte(8'h86, ack); chk("mm_no_ack", ack, 0);
        chk("mm_busy", bus.busy, 0);
        chk("mm_oe_never", oe_n - obase, 0);
        i2c_stop();
        clks(4);
        chk("mm_no_write", wr_n - base, 0);
        chk("mm_no_read", rd_n - rbase, 0);

        base = wr_n;
        i2c_start();
        write_byte(8'h84, ack); chk("sm_addr_ack", ack, 1);
        write_byte(8'h30, ack); chk("sm_ptr_ack", ack, 1);
        bit_cycle(1'b1, s); bit_cycle(1'b0, s); bit_cycle(1'b1, s); bit_cycle(1'b1, s);
        i2c_stop();
        clks(4);
        chk("sm_no_write", wr_n - base, 0);
        chk("sm_busy", bus.busy, 0);
        chk("sm_oe", bus.sda_oe, 0);
        i2c_start();
        write_byte(8'h84, ack); chk("sm_next_addr_ack", ack, 1);
        write_byte(8'h40, ack); chk("sm_next_ptr_ack", ack, 1);
        write_byte(8'h77, ack); chk("sm_next_data_ack", ack, 1);
        i2c_stop();
        clks(4);
        chk("sm_next_count", wr_n - base, 1);
        chk("sm_next_write", wr_log[base[5:0]], 16'h4077);

        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h50, ack);
        i2c_start();
        write_byte(8'h85, ack); chk("rr_addr_ack", ack, 1);
        bit_cycle(1'b1, s); chk("rr_bit7", s, 1);
        clks(5);
        chk("rr_oe_before_reset", bus.sda_oe, 1);
        rst_n = 1'b0;
        clks(1);
        chk("rr_sda_oe", bus.sda_oe, 0);
        chk("rr_wr_valid", bus.wr_valid, 0);
        chk("rr_rd_req", bus.rd_req, 0);
        chk("rr_busy", bus.busy, 0);
        chk("rr_wr_ptr", bus.wr_ptr, 0);
        chk("rr_wr_data", bus.wr_data, 0);
        chk("rr_rd_ptr", bus.rd_ptr, 0);
        rst_n = 1'b1;
        clks(3);
        i2c_stop();
        rbase = rd_n;
        i2c_start();
        write_byte(8'h85, ack); chk("rr_after_addr_ack", ack, 1);
        read_byte(1'b0, d); chk("rr_after_data", d, 8'hFF);
        clks(2);
        chk("rr_after_ptr", rd_log[rbase[5:0]], 8'h00);
        i2c_stop();
        clks(4);

        chk("no_wr_rd_overlap", both_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
